// File: rtl/ascon_perm_core_pkg.sv
// Shared types and constants for the Ascon permutation core: state layout,
// FSM encoding, linear-layer rotate amounts and round-constant helpers.
package ascon_perm_core_pkg;

    localparam int ASCON_ROUNDS = 12;
    localparam int WORDS        = 5;

    typedef logic [63:0] word_t;
    typedef word_t state_t [WORDS];

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } perm_state_e;

    // Linear diffusion: x[i] ^= ror(x[i], ROT_A[i]) ^ ror(x[i], ROT_B[i])
    localparam int ROT_A [WORDS] = '{19, 61, 1, 10, 7};
    localparam int ROT_B [WORDS] = '{28, 39, 6, 17, 41};

    // Round r constant: high nibble counts down from F, low nibble counts up.
    function automatic logic [7:0] round_const(input logic [3:0] r);
        return {4'hF - r, r};
    endfunction

    function automatic word_t ror64(input word_t x, input int k);
        return (x >> k) | (x << (64 - k));
    endfunction

endpackage

// File: rtl/ascon_perm_core_round.sv
// One combinational Ascon round (constant addition, S-box layer, linear layer)
// plus the bit-sliced 5-bit S-box layer it instantiates.
module substitute
    import ascon_perm_core_pkg::*;
(
    input  state_t state,
    output state_t result
);

    state_t a;
    state_t t;
    state_t b;

    // NOTE: blocking assignments here; each intermediate is consumed later in the same evaluation.
    always_comb begin
        a[0] = state[0] ^ state[4];
        a[1] = state[1];
        a[2] = state[2] ^ state[1];
        a[3] = state[3];
        a[4] = state[4] ^ state[3];
        for (int i = 0; i < WORDS; i++) begin
            t[i] = ~a[i] & a[(i + 1) % WORDS];
        end
        for (int i = 0; i < WORDS; i++) begin
            b[i] = a[i] ^ t[(i + 1) % WORDS];
        end
        result[0] = b[0] ^ b[4];
        result[1] = b[1] ^ b[0];
        result[2] = ~b[2];
        result[3] = b[3] ^ b[2];
        result[4] = b[4];
    end

endmodule

module ascon_round
    import ascon_perm_core_pkg::*;
(
    output state_t     result,
    input  state_t     state,
    input  logic [3:0] r
);

    state_t added;
    state_t sboxed;

    always_comb begin
        for (int i = 0; i < WORDS; i++) begin
            added[i] = state[i];
        end
        added[2] = state[2] ^ {56'd0, round_const(r)};
    end

    substitute u_sbox (
        .state  (added),
        .result (sboxed)
    );

    always_comb begin
        for (int i = 0; i < WORDS; i++) begin
            result[i] = sboxed[i] ^ ror64(sboxed[i], ROT_A[i]) ^ ror64(sboxed[i], ROT_B[i]);
        end
    end

endmodule

// File: rtl/ascon_perm_core.sv
// Iterative Ascon p[n] engine with valid/ready handshakes on both sides.
// Optional build macro ASCON_PERM_ZEROIZE_EN clears state and out_state after each output handshake.
module ascon_perm_core
    import ascon_perm_core_pkg::*;
#(
    parameter int UNROLL     = 1,
    parameter int MAX_ROUNDS = ASCON_ROUNDS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_state [5],
    input  logic [3:0]  in_rounds,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_state [5],
    output logic        out_err,
    busy
);

    generate
        if (UNROLL != 1 && UNROLL != 2) begin : g_bad_unroll
            $error("ascon_perm_core: UNROLL must be 1 or 2");
        end
        if (MAX_ROUNDS != ASCON_ROUNDS) begin : g_bad_rounds
            $error("ascon_perm_core: MAX_ROUNDS must be 12");
        end
    endgenerate

    localparam logic [3:0] STEP = 4'(UNROLL);
    localparam logic [3:0] LAST = 4'(MAX_ROUNDS);

    perm_state_e fsm;
    state_t      st_q;
    logic [3:0]  r_q;

    state_t      round_in;
    state_t      round_out;
    logic [3:0]  r_base;
    logic [3:0]  r_next;
    logic        last;
    logic        legal;

    // The first UNROLL rounds are applied on the accept edge, so n/UNROLL edges produce the result.
    always_comb begin
        for (int i = 0; i < WORDS; i++) begin
            round_in[i] = (fsm == S_IDLE) ? in_state[i] : st_q[i];
        end
        r_base = (fsm == S_IDLE) ? (LAST - in_rounds) : r_q;
        r_next = r_base + STEP;
        last   = (r_next == LAST);
        legal  = (in_rounds != 4'd0) && (in_rounds <= LAST) &&
                 ((UNROLL == 1) || !in_rounds[0]);
    end

    generate
        if (UNROLL == 2) begin : g_two
            state_t round_mid;
            ascon_round u_round0 (
                .result (round_mid),
                .state  (round_in),
                .r      (r_base)
            );
            ascon_round u_round1 (
                .result (round_out),
                .state  (round_mid),
                .r      (r_base + 4'd1)
            );
        end else begin : g_one
            ascon_round u_round0 (
                .result (round_out),
                .state  (round_in),
                .r      (r_base)
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the wide state registers are reset too, so out_state reads 0 straight after reset.
            fsm       <= S_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_err   <= 1'b0;
            busy      <= 1'b0;
            r_q       <= 4'd0;
            st_q      <= '{default: '0};
            out_state <= '{default: '0};
        end else begin
            case (fsm)
                S_IDLE: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        if (!legal) begin
                            out_state <= in_state;
                            out_err   <= 1'b1;
                            out_valid <= 1'b1;
                            fsm       <= S_DONE;
                        end else begin
                            st_q    <= round_out;
                            r_q     <= r_next;
                            out_err <= 1'b0;
                            if (last) begin
                                out_state <= round_out;
                                out_valid <= 1'b1;
                                fsm       <= S_DONE;
                            end else begin
                                fsm <= S_RUN;
                            end
                        end
                    end
                end
                S_RUN: begin
                    st_q <= round_out;
                    r_q  <= r_next;
                    if (last) begin
                        out_state <= round_out;
                        out_valid <= 1'b1;
                        fsm       <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        fsm       <= S_IDLE;
`ifdef ASCON_PERM_ZEROIZE_EN
                        st_q      <= '{default: '0};
                        out_state <= '{default: '0};
`endif
                    end
                end
                default: begin
                    fsm <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ascon_perm_core.sv
// Scoreboard bench for ascon_perm_core: UNROLL=1 and UNROLL=2 instances share stimulus
// and are compared against a table-driven Ascon reference model.
module tb_ascon_perm_core;
    import ascon_perm_core_pkg::*;

    typedef logic [4:0][63:0] pst_t;
    typedef struct {
        pst_t st;
        logic err;
        int   lat;
    } exp_t;

`ifdef ASCON_PERM_ZEROIZE_EN
    localparam bit ZEROIZE = 1'b1;
`else
    localparam bit ZEROIZE = 1'b0;
`endif

    localparam logic [4:0] SBOX [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
    localparam int RA [5] = '{19, 61, 1, 10, 7};
    localparam int RB [5] = '{28, 39, 6, 17, 41};

    int checks = 0;
    int errors = 0;
    exp_t sb1[$];
    exp_t sb2[$];

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [3:0]  in_rounds;
    logic [63:0] in_state [5];
    pst_t        drv;
    logic        in_ready1, out_valid1, out_err1, busy1;
    logic        in_ready2, out_valid2, out_err2, busy2;
    logic [63:0] out_state1 [5];
    logic [63:0] out_state2 [5];
    pst_t        obs1, obs2;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < 5; i++) begin
            in_state[i] = drv[i];
            obs1[i]     = out_state1[i];
            obs2[i]     = out_state2[i];
        end
    end

    ascon_perm_core #(.UNROLL(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .in_state(in_state), .in_rounds(in_rounds), .out_valid(out_valid1),
        .out_ready(out_ready), .out_state(out_state1), .out_err(out_err1), .busy(busy1));

    ascon_perm_core #(.UNROLL(2)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .in_state(in_state), .in_rounds(in_rounds), .out_valid(out_valid2),
        .out_ready(out_ready), .out_state(out_state2), .out_err(out_err2), .busy(busy2));

    task automatic check(input string tag, input logic [319:0] obs, input logic [319:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] rotr(input logic [63:0] x, input int k);
        logic [127:0] d;
        d = {x, x} >> k;
        return d[63:0];
    endfunction

    function automatic pst_t model(input pst_t s, input int n);
        pst_t t;
        for (int r = 12 - n; r < 12; r++) begin
            s[2][7:0] = s[2][7:0] ^ 8'(((15 - r) << 4) | r);
            for (int b = 0; b < 64; b++) begin
                logic [4:0] v;
                v = SBOX[{s[0][b], s[1][b], s[2][b], s[3][b], s[4][b]}];
                t[0][b] = v[4];
                t[1][b] = v[3];
                t[2][b] = v[2];
                t[3][b] = v[1];
                t[4][b] = v[0];
            end
            for (int i = 0; i < 5; i++) begin
                s[i] = t[i] ^ rotr(t[i], RA[i]) ^ rotr(t[i], RB[i]);
            end
        end
        return s;
    endfunction

    function automatic pst_t rand_st();
        pst_t s;
        for (int i = 0; i < 5; i++) s[i] = {$urandom, $urandom};
        return s;
    endfunction

    task automatic wait_ready();
        int cyc = 0;
        while (!(in_ready1 && in_ready2) && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("ready_before_req", {in_ready1, in_ready2}, 2'b11);
    endtask

    task automatic do_req(input pst_t st, input int n, input int hold);
        int   cyc;
        bit   d1, d2, legal1, legal2;
        exp_t e;
        pst_t last1, last2;
        wait_ready();
        drv       = st;
        in_rounds = 4'(n);
        in_valid  = 1'b1;
        legal1    = (n >= 1) && (n <= 12);
        legal2    = legal1 && (n % 2 == 0);
        e.st = legal1 ? model(st, n) : st;  e.err = !legal1;  e.lat = legal1 ? n : 1;
        sb1.push_back(e);
        e.st = legal2 ? model(st, n) : st;  e.err = !legal2;  e.lat = legal2 ? n / 2 : 1;
        sb2.push_back(e);
        @(negedge clk);
        in_valid  = 1'b0;
        drv       = rand_st();
        in_rounds = 4'($urandom);
        d1 = 0; d2 = 0; cyc = 1; last1 = '0; last2 = '0;
        while (!(d1 && d2) && cyc <= 40) begin
            if (out_valid2 && !d2) begin
                e = sb2.pop_front();
                check("u2_latency", cyc, e.lat);
                check("u2_state", obs2, e.st);
                check("u2_err", out_err2, e.err);
                last2 = obs2;
                d2 = 1;
            end
            if (out_valid1 && !d1) begin
                e = sb1.pop_front();
                check("u1_latency", cyc, e.lat);
                check("u1_state", obs1, e.st);
                check("u1_err", out_err1, e.err);
                last1 = obs1;
                d1 = 1;
                if (hold > 0) begin
                    out_ready = 1'b0;
                    for (int h = 0; h < hold; h++) begin
                        @(negedge clk);
                        check("hold_state", obs1, e.st);
                        check("hold_valid", out_valid1, 1'b1);
                        check("hold_in_ready", in_ready1, 1'b0);
                    end
                    out_ready = 1'b1;
                end
            end
            if (!(d1 && d2)) begin
                if (!d1) check("u1_busy", busy1, 1'b1);
                @(negedge clk);
                cyc++;
            end
        end
        check("out_valid_timeout", {d1, d2}, 2'b11);
        @(negedge clk);
        check("u1_ready_after", in_ready1, 1'b1);
        check("u1_valid_after", out_valid1, 1'b0);
        check("u1_busy_after", busy1, 1'b0);
        check("u1_state_after", obs1, ZEROIZE ? '0 : last1);
        check("u2_state_after", obs2, ZEROIZE ? '0 : last2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit seen;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drv       = '0;
        in_rounds = 4'd0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", {in_ready1, in_ready2}, 2'b11);
        check("rst_out_valid", {out_valid1, out_valid2}, 2'b00);
        check("rst_out_err", {out_err1, out_err2}, 2'b00);
        check("rst_busy", {busy1, busy2}, 2'b00);
        check("rst_state1", obs1, '0);
        check("rst_state2", obs2, '0);
        rst = 1'b0;
        @(negedge clk);

        // all-zero state through p12 on both unroll factors
        do_req('0, 12, 0);
        // reduced round counts on random states
        do_req(rand_st(), 6, 0);
        do_req(rand_st(), 8, 0);
        // illegal round counts take the error path
        do_req(rand_st(), 0, 0);
        do_req(rand_st(), 13, 0);
        // consumer stalls in DONE, then a string of requests in order
        do_req(rand_st(), 12, 5);
        do_req(rand_st(), 4, 0);
        do_req(rand_st(), 10, 0);
        do_req(rand_st(), 2, 0);
        do_req(rand_st(), 1, 0);
        do_req(rand_st(), 11, 0);
        do_req(rand_st(), 15, 0);

        // reset in the middle of a run abandons the operation
        wait_ready();
        drv       = rand_st();
        in_rounds = 4'd12;
        in_valid  = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("rst_run_busy", busy1, 1'b1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid1 || out_valid2) seen = 1;
        end
        check("rst_mid_no_valid", seen, 1'b0);
        check("rst_mid_in_ready", {in_ready1, in_ready2}, 2'b11);
        check("rst_mid_busy", {busy1, busy2}, 2'b00);
        check("rst_mid_state1", obs1, '0);
        sb1.delete();
        sb2.delete();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
